// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared pipeline control types and constants
package pipeline_pkg;

    localparam int REG_IDX_W = 4;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ABORT    = 2'd2
    } fsm_state_t;

    // Control bundle carried by the ID/EX and EX/MEM pipeline registers
    typedef struct packed {
        logic wb_en;
        logic mem_r_en;
        logic mem_w_en;
        logic b;
        logic s;
    } pipe_ctrl_t;

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational register-dependency compare for decode operands
module hazard_detect
    import pipeline_pkg::*;
#(
    parameter int FWD_EN = 1
) (
    input  logic                 id_valid,
    input  logic [REG_IDX_W-1:0] id_src1,
    input  logic [REG_IDX_W-1:0] id_src2,
    input  logic                 id_two_src,
    input  logic                 exe_wb_en,
    input  logic                 exe_mem_r_en,
    input  logic [REG_IDX_W-1:0] exe_dest,
    input  logic                 exe_b,
    input  logic                 mem_wb_en,
    input  logic [REG_IDX_W-1:0] mem_dest,
    output logic                 hit1,
    output logic                 hit2,
    output logic                 hazard
);

    // With forwarding only a load in EXE cannot be bypassed; without it every
    // pending writeback in EXE or MEM blocks the dependent instruction.
    logic exe_blocks;
    logic mem_blocks;

    assign exe_blocks = exe_wb_en & ((FWD_EN != 0) ? exe_mem_r_en : 1'b1);
    assign mem_blocks = (FWD_EN == 0) ? mem_wb_en : 1'b0;

    assign hit1 = (exe_blocks & (exe_dest == id_src1)) |
                  (mem_blocks & (mem_dest == id_src1));
    assign hit2 = (exe_blocks & (exe_dest == id_src2)) |
                  (mem_blocks & (mem_dest == id_src2));

    // A taken branch in EXE squashes decode anyway, so no stall is needed.
    assign hazard = id_valid & ~exe_b & (hit1 | (id_two_src & hit2));

endmodule

// File: rtl/hazard_flush_ctrl.sv
// rtl/hazard_flush_ctrl.sv - pipeline flush/freeze generation with memory wait FSM
module hazard_flush_ctrl
    import pipeline_pkg::*;
#(
    parameter int FWD_EN      = 1,
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    input  logic [REG_IDX_W-1:0] id_src1,
    input  logic [REG_IDX_W-1:0] id_src2,
    input  logic                 id_two_src,
    input  logic                 exe_wb_en,
    input  logic                 exe_mem_r_en,
    input  logic [REG_IDX_W-1:0] exe_dest,
    input  logic                 exe_b,
    input  logic                 mem_wb_en,
    input  logic [REG_IDX_W-1:0] mem_dest,
    input  logic                 mem_req,
    input  logic                 mem_ready,
    output logic                 freeze_pc,
    output logic                 freeze_ifid,
    output logic                 flush_ifid,
    output logic                 flush_idex,
    output logic                 freeze_all,
    output logic                 mem_err,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [1:0]           state
);

    localparam logic [15:0] WAIT_LAST = 16'(MEM_TIMEOUT - 1);

    fsm_state_t       state_q;
    logic [15:0]      wait_cnt;
    logic             mem_err_q;
    logic [CNT_W-1:0] stall_cnt_q;

    // While reset is asserted every input is forced to zero so all control
    // outputs go low regardless of what the pipeline presents.
    logic                 g_id_valid, g_two_src, g_exe_wb_en, g_exe_mem_r_en;
    logic                 g_exe_b, g_mem_wb_en, g_mem_req, g_mem_ready;
    logic [REG_IDX_W-1:0] g_src1, g_src2, g_exe_dest, g_mem_dest;

    assign g_id_valid     = rst & id_valid;
    assign g_two_src      = rst & id_two_src;
    assign g_exe_wb_en    = rst & exe_wb_en;
    assign g_exe_mem_r_en = rst & exe_mem_r_en;
    assign g_exe_b        = rst & exe_b;
    assign g_mem_wb_en    = rst & mem_wb_en;
    assign g_mem_req      = rst & mem_req;
    assign g_mem_ready    = rst & mem_ready;
    assign g_src1         = rst ? id_src1  : '0;
    assign g_src2         = rst ? id_src2  : '0;
    assign g_exe_dest     = rst ? exe_dest : '0;
    assign g_mem_dest     = rst ? mem_dest : '0;

    logic hit1, hit2, hazard;

    hazard_detect #(
        .FWD_EN(FWD_EN)
    ) u_hazard_detect (
        .id_valid     (g_id_valid),
        .id_src1      (g_src1),
        .id_src2      (g_src2),
        .id_two_src   (g_two_src),
        .exe_wb_en    (g_exe_wb_en),
        .exe_mem_r_en (g_exe_mem_r_en),
        .exe_dest     (g_exe_dest),
        .exe_b        (g_exe_b),
        .mem_wb_en    (g_mem_wb_en),
        .mem_dest     (g_mem_dest),
        .hit1         (hit1),
        .hit2         (hit2),
        .hazard       (hazard)
    );

    // In ABORT the stall is released so the pipeline moves past the dead access.
    logic mem_stall;
    assign mem_stall = g_mem_req & ~g_mem_ready & (state_q != ST_ABORT);

    // Priority: a memory freeze masks flushes; a branch beats a load-use bubble
    // (hazard already excludes the branch case).
    always_comb begin
        freeze_all  = mem_stall;
        freeze_pc   = mem_stall | hazard;
        freeze_ifid = mem_stall | hazard;
        flush_ifid  = ~mem_stall & g_exe_b;
        flush_idex  = ~mem_stall & (g_exe_b | hazard);
    end

    // Memory wait FSM with timeout, sticky error flag and saturating stall counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_RUN;
            wait_cnt    <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            if (freeze_pc && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            case (state_q)
                ST_RUN: begin
                    if (mem_stall) begin
                        state_q  <= ST_MEM_WAIT;
                        wait_cnt <= 16'd1;
                    end
                end
                ST_MEM_WAIT: begin
                    if (g_mem_ready) begin
                        state_q  <= ST_RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state_q   <= ST_ABORT;
                        wait_cnt  <= '0;
                        mem_err_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                ST_ABORT: begin
                    state_q  <= ST_RUN;
                    wait_cnt <= '0;
                end
                default: begin
                    state_q  <= ST_RUN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    assign mem_err   = mem_err_q;
    assign stall_cnt = stall_cnt_q;
    assign state     = state_q;

    logic unused_hits;
    assign unused_hits = hit1 ^ hit2;

endmodule

// File: doc/hazard_flush_ctrl.md
Name: hazard_flush_ctrl

Overview:
- Control block that produces the flush/freeze signals consumed by the ID/EX pipeline register and the IF, IF/ID and EX/MEM stages.
- Inspects the decode-stage operands and the registered ID/EX and EX/MEM control outputs.
- Generates:
  - branch flushes;
  - load-use bubbles (data hazards when forwarding is off);
  - global freezes while the data memory is not ready, with a timeout.
- Holds a small FSM for memory wait/abort and a saturating stall counter.

Parameters:
- FWD_EN, 0, 1 = forwarding unit present; only load-use hazards stall. 0 = any pending writeback to a source register stalls.
- MEM_TIMEOUT, 64, max consecutive cycles in MEM_WAIT before abort; legal range 2..65535.
- CNT_W, 16, width of the stall statistics counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-low reset (asserted when 0)
- id_valid  in  1  decode stage holds a real instruction
- id_src1  in  4  Rn index in decode
- id_src2  in  4  Rm/Rd index in decode
- id_two_src  in  1  id_src2 is actually read
- exe_wb_en  in  1  ID/EX register wb_en output
- exe_mem_r_en  in  1  ID/EX register mem_r_en output
- exe_dest  in  4  ID/EX register dest output
- exe_b  in  1  ID/EX register b output (branch in EXE, taken)
- mem_wb_en  in  1  EX/MEM wb_en
- mem_dest  in  4  EX/MEM dest
- mem_req  in  1  EX/MEM has mem_r_en or mem_w_en
- mem_ready  in  1  data memory completes this cycle
- freeze_pc  out  1  hold PC
- freeze_ifid  out  1  hold IF/ID register
- flush_ifid  out  1  clear IF/ID register
- flush_idex  out  1  drives ID/EX register flush
- freeze_all  out  1  hold every pipeline register, including ID/EX
- mem_err  out  1  sticky: a memory access timed out
- stall_cnt  out  CNT_W  saturating count of cycles with freeze_pc=1
- state  out  2  FSM state, for debug

Behaviour:
- Reset (rst=0 at a clk edge): state=RUN, wait counter=0, mem_err=0, stall_cnt=0.
  - All combinational outputs evaluate as if all inputs are 0, so every control output is 0.
  - Reset mid-MEM_WAIT aborts the wait immediately. Memory handshake cleanup is the memory controller's job.
- FSM states: RUN=0, MEM_WAIT=1, ABORT=2. Encoding 3 is illegal and recovers to RUN on the next edge.
- mem_stall = mem_req & ~mem_ready & (state != ABORT).
- freeze_all = mem_stall. This is combinational, so it is already asserted in the first cycle the access is not ready.
- Transitions:
  - RUN -> MEM_WAIT when mem_stall; the wait counter loads 1.
  - MEM_WAIT -> RUN when mem_ready; the counter clears.
  - MEM_WAIT -> ABORT when the counter == MEM_TIMEOUT-1 and mem_ready=0. mem_err sets (sticky until reset).
  - MEM_WAIT otherwise: the counter increments.
  - ABORT -> RUN unconditionally after 1 cycle. freeze_all=0 in ABORT so the pipeline advances past the access.
- Hazard detection (combinational, evaluated in all states):
  - hit(r) = (exe_wb_en & exe_dest==r) | (~FWD_EN & mem_wb_en & mem_dest==r).
  - With FWD_EN=1, the exe term additionally requires exe_mem_r_en.
  - hazard = id_valid & ~exe_b & (hit(id_src1) | (id_two_src & hit(id_src2))).
- Branch: when exe_b=1, flush_ifid=1 and flush_idex=1.
- Hazard without branch: freeze_pc=1, freeze_ifid=1, flush_idex=1 (bubble).
- Priority: freeze_all masks everything.
  - When freeze_all=1: flush_ifid=0, flush_idex=0, freeze_pc=1, freeze_ifid=1.
  - Branch beats hazard: no freeze on a branch cycle.
  - A branch arriving while frozen is held by the frozen ID/EX register and flushes on the first unfrozen cycle.
- stall_cnt: +1 on each clk edge where freeze_pc=1. It saturates at all-ones and never wraps.
- All outputs except mem_err, stall_cnt and state are combinational. There is zero-cycle latency from input to flush/freeze.

Decomposition:
- Shared package (pipeline_pkg) holds:
  - FSM state constants RUN/MEM_WAIT/ABORT;
  - the register-index width constant (4);
  - a pipe_ctrl_t grouping wb_en/mem_r_en/mem_w_en/b/s, also used by the pipeline registers.
- Sub-module hazard_detect:
  - purely combinational hit/hazard compare;
  - reused by the forwarding unit.
- The FSM, counters and priority muxing live in the top module.

Test Plan:
- Reset: hold rst=0 for 2 cycles with mem_req=1, exe_b=1 -> all outputs 0, stall_cnt=0; release -> flush_ifid=flush_idex=1 the same cycle.
- Load-use, FWD_EN=1:
  - id_valid=1, id_src1=3, exe_wb_en=1, exe_mem_r_en=1, exe_dest=3 -> freeze_pc=freeze_ifid=flush_idex=1 for 1 cycle, stall_cnt 0->1.
  - Same with exe_mem_r_en=0 -> no stall.
- FWD_EN=0 second source: id_two_src=1, id_src2=5, mem_wb_en=1, mem_dest=5 -> stall. With id_two_src=0 -> no stall.
- Memory wait: mem_req=1, mem_ready low for 3 cycles then high -> freeze_all=1 for exactly 3 cycles, state 1 then back to 0, mem_err=0.
- Timeout with MEM_TIMEOUT=4: mem_ready never rises -> freeze_all high 4 cycles, then ABORT (freeze_all=0, mem_err=1), then RUN. mem_err stays 1 until rst=0.
- Branch during freeze: exe_b=1 with mem_stall active -> flush_*=0. After mem_ready, flush_ifid=flush_idex=1 in that unfrozen cycle. Also check stall_cnt saturation with CNT_W=2 after 5 stall cycles -> value 3.
